// File: rtl/xadc_sample_sequencer.sv
// xadc_sample_sequencer
// Periodically sweeps XADC aux channels VAUX0..3 over the DRP port. Each sweep
// result is packed into a 32-bit word for the AXI4-Lite bridge, and per-channel
// spike flags are derived against a programmable threshold. DRP timeouts and
// dropped sweep ticks (overruns) are recorded in sticky status bits.
module xadc_sample_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 10000,
  parameter int unsigned DRP_TIMEOUT   = 64,
  parameter logic [6:0]  BASE_ADDR     = 7'h10
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        enable,
  input  logic [11:0] threshold,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [31:0] net_out,
  output logic        net_out_valid,
  output logic [3:0]  spike_bits,
  output logic [15:0] sample_count,
  output logic [1:0]  status
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int TW = $clog2(DRP_TIMEOUT + 1);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PERIOD_ONE   = PW'(1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(DRP_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RDY = 3'd2,
    NEXT     = 3'd3,
    PUBLISH  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [PW-1:0] period_cnt_r;
  logic [TW-1:0] wait_cnt_r;
  logic [1:0]    ch_r;
  logic [1:0]    ch_next_s;
  logic          abort_r;
  logic [11:0]   chan_r [4];

  logic          tick_s;
  logic          capture_s;
  logic          timeout_s;
  logic          done_s;
  logic          stop_s;
  logic          overrun_s;
  logic          den_next_s;
  logic          publish_s;
  logic [3:0]    spike_next_s;
  logic [31:0]   net_next_s;
  logic          unused_do_s;

  // The DRP write side is never used; the low nibble of read data carries no sample bits.
  assign drp_dwe     = 1'b0;
  assign drp_di      = 16'h0000;
  assign unused_do_s = ^drp_do[3:0];

  assign tick_s    = enable && (period_cnt_r == PERIOD_LAST);
  assign capture_s = (state_r == WAIT_RDY) && drp_drdy;
  assign timeout_s = (state_r == WAIT_RDY) && !drp_drdy && (wait_cnt_r == TIMEOUT_LAST);
  assign done_s    = capture_s || timeout_s;
  assign stop_s    = abort_r || !enable;
  assign overrun_s = tick_s && (state_r != IDLE);

  // Sweep-start period counter; parked at zero whenever sweeping is disabled.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      period_cnt_r <= '0;
    end else if (!enable || (period_cnt_r == PERIOD_LAST)) begin
      period_cnt_r <= '0;
    end else begin
      period_cnt_r <= period_cnt_r + PERIOD_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a disable mid-sweep lets the current read finish, then idles.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (tick_s) state_next_s = REQ;
        else        state_next_s = IDLE;
      end
      REQ: state_next_s = WAIT_RDY;
      WAIT_RDY: begin
        if (done_s) begin
          if (stop_s) state_next_s = IDLE;
          else        state_next_s = NEXT;
        end else begin
          state_next_s = WAIT_RDY;
        end
      end
      NEXT: begin
        if (stop_s)              state_next_s = IDLE;
        else if (ch_r == 2'd3)   state_next_s = PUBLISH;
        else                     state_next_s = REQ;
      end
      PUBLISH: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: next-cycle values for the registered DRP and publish outputs.
  always_comb begin
    den_next_s = (state_next_s == REQ);
    publish_s  = (state_r == PUBLISH);
    if ((state_r == IDLE) && tick_s) begin
      ch_next_s = 2'd0;
    end else if ((state_r == NEXT) && (state_next_s == REQ)) begin
      ch_next_s = ch_r + 2'd1;
    end else begin
      ch_next_s = ch_r;
    end
    for (int i = 0; i < 4; i++) begin
      spike_next_s[i] = (chan_r[i] >= threshold);
    end
    net_next_s = {chan_r[3][11:4], chan_r[2][11:4], chan_r[1][11:4], chan_r[0][11:4]};
  end

  // Remembers that enable dropped during a sweep so the sweep is abandoned.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      abort_r <= 1'b0;
    end else if (state_r == IDLE) begin
      abort_r <= 1'b0;
    end else if (!enable) begin
      abort_r <= 1'b1;
    end else begin
      abort_r <= abort_r;
    end
  end

  // Cycles spent waiting for drdy on the current read.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wait_cnt_r <= '0;
    end else if (state_r == WAIT_RDY) begin
      wait_cnt_r <= wait_cnt_r + TIMEOUT_ONE;
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Channel index and DRP request outputs; the address holds between reads.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ch_r      <= 2'd0;
      drp_den   <= 1'b0;
      drp_daddr <= 7'h00;
    end else begin
      ch_r    <= ch_next_s;
      drp_den <= den_next_s;
      if (den_next_s) begin
        drp_daddr <= BASE_ADDR + {5'b00000, ch_next_s};
      end else begin
        drp_daddr <= drp_daddr;
      end
    end
  end

  // Per-channel sample slots; a timed-out read leaves the old sample in place.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        chan_r[i] <= 12'h000;
      end
    end else if (capture_s) begin
      chan_r[ch_r] <= drp_do[15:4];
    end
  end

  // Publish the completed sweep: word, spike flags and sweep count move together.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      net_out       <= 32'h0000_0000;
      net_out_valid <= 1'b0;
      spike_bits    <= 4'h0;
      sample_count  <= 16'h0000;
    end else begin
      net_out_valid <= publish_s;
      if (publish_s) begin
        net_out      <= net_next_s;
        spike_bits   <= spike_next_s;
        sample_count <= sample_count + 16'd1;
      end else begin
        net_out      <= net_out;
        spike_bits   <= spike_bits;
        sample_count <= sample_count;
      end
    end
  end

  // Sticky error flags: [0] DRP read timeout, [1] sweep tick dropped while busy.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      status <= 2'b00;
    end else begin
      status <= status | {overrun_s, timeout_s};
    end
  end

endmodule

// File: tb/tb_xadc_sample_sequencer.sv
// Directed bench for xadc_sample_sequencer with a behavioural DRP responder and
// a queue of expected publish results.
module tb_xadc_sample_sequencer;

  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] threshold;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic [31:0] net_out;
  logic        net_out_valid;
  logic [3:0]  spike_bits;
  logic [15:0] sample_count;
  logic [1:0]  status;

  always #5 clk = ~clk;

  xadc_sample_sequencer #(
    .SAMPLE_PERIOD(PERIOD),
    .DRP_TIMEOUT  (64),
    .BASE_ADDR    (7'h10)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .enable       (enable),
    .threshold    (threshold),
    .drp_den      (drp_den),
    .drp_daddr    (drp_daddr),
    .drp_dwe      (drp_dwe),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .net_out      (net_out),
    .net_out_valid(net_out_valid),
    .spike_bits   (spike_bits),
    .sample_count (sample_count),
    .status       (status)
  );

  // DRP responder: answers each read after lat cycles unless that channel is withheld.
  logic [11:0] vals [4];
  int          lat = 3;
  int          withhold = -1;
  logic        pending;
  int          cnt;
  logic [1:0]  req_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      cnt      <= 0;
      req_idx  <= 2'd0;
      drp_drdy <= 1'b0;
      drp_do   <= 16'hDEAD;
    end else begin
      drp_drdy <= 1'b0;
      drp_do   <= 16'hDEAD;
      if (pending) begin
        if (cnt <= 1) begin
          drp_drdy <= 1'b1;
          drp_do   <= {vals[req_idx], 4'h5};
          pending  <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (drp_den) begin
        req_idx <= drp_daddr[1:0];
        if (int'(drp_daddr[1:0]) != withhold) begin
          pending <= 1'b1;
          cnt     <= lat;
        end
      end
    end
  end

  // Activity monitor sampled on the falling edge.
  int         cyc = 0;
  int         den_count = 0;
  int         valid_count = 0;
  int         den_wide = 0;
  logic       den_prev = 1'b0;
  logic [6:0] daddr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    den_prev <= drp_den;
    if (drp_den) begin
      den_count <= den_count + 1;
      daddr_q.push_back(drp_daddr);
      if (den_prev) den_wide <= den_wide + 1;
    end
    if (net_out_valid) valid_count <= valid_count + 1;
  end

  typedef struct packed {
    logic [31:0] net;
    logic [3:0]  spk;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] net, input logic [3:0] spk, input logic [15:0] c);
    exp_t e;
    e.net = net;
    e.spk = spk;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_publish(input int budget, output int at_cyc);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (net_out_valid) seen = 1'b1;
    end
    vectors++;
    assert (seen === 1'b1) else begin
      miscompares++;
      $error("FAIL publish_wait: no net_out_valid within %0d cycles", budget);
    end
    if (seen) begin
      at_cyc = cyc;
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL scoreboard: unexpected publish, observed net_out %0h", net_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("net_out", net_out, e.net);
        check("spike_bits", {28'd0, spike_bits}, {28'd0, e.spk});
        check("sample_count", {16'd0, sample_count}, {16'd0, e.cnt});
      end
      @(negedge clk);
      check("valid_one_cycle", {31'd0, net_out_valid}, 32'd0);
    end
  endtask

  task automatic wait_den(input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      n++;
      if (drp_den) seen = 1'b1;
    end
    vectors++;
    assert (seen === 1'b1) else begin
      miscompares++;
      $error("FAIL den_wait: no drp_den within %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_net_out"}, net_out, 32'd0);
    check({tag, "_valid"}, {31'd0, net_out_valid}, 32'd0);
    check({tag, "_spike"}, {28'd0, spike_bits}, 32'd0);
    check({tag, "_count"}, {16'd0, sample_count}, 32'd0);
    check({tag, "_status"}, {30'd0, status}, 32'd0);
    check({tag, "_den"}, {31'd0, drp_den}, 32'd0);
    check({tag, "_daddr"}, {25'd0, drp_daddr}, 32'd0);
  endtask

  int  n, p1, p2, p3, p4, p5, p6, dc, vc;
  bit  found;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    threshold = 12'h000;
    vals[0] = 12'hFFF; vals[1] = 12'h800; vals[2] = 12'h100; vals[3] = 12'h000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("dwe_tied", {31'd0, drp_dwe}, 32'd0);
    check("di_tied", {16'd0, drp_di}, 32'd0);

    // Basic sweep
    threshold = 12'h800;
    push_exp(32'h0010_80FF, 4'b0011, 16'd1);
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_den(PERIOD + 5, n);
    check("first_tick_latency", n, PERIOD);
    wait_publish(400, p1);

    // Three consecutive sweeps, threshold 0 and fresh data
    threshold = 12'h000;
    push_exp(32'h0010_80FF, 4'b1111, 16'd2);
    wait_publish(400, p2);
    vals[0] = 12'h123; vals[1] = 12'hABC; vals[2] = 12'h7FF; vals[3] = 12'h801;
    threshold = 12'h800;
    push_exp(32'h807F_AB12, 4'b1010, 16'd3);
    wait_publish(400, p3);
    check("spacing_1_2", p2 - p1, PERIOD);
    check("spacing_2_3", p3 - p2, PERIOD);
    check("daddr_q_size", daddr_q.size(), 12);
    for (int i = 0; i < 12 && i < daddr_q.size(); i++) begin
      check("daddr_seq", {25'd0, daddr_q[i]}, 32'h10 + (i % 4));
    end
    check("den_width", den_wide, 0);
    check("den_count", den_count, 12);
    check("status_clean", {30'd0, status}, 32'd0);

    // ch2 never answers: timeout, old ch2 sample retained
    vals[0] = 12'h200; vals[1] = 12'h300; vals[2] = 12'h555; vals[3] = 12'h400;
    withhold  = 2;
    threshold = 12'h300;
    push_exp(32'h407F_3020, 4'b1110, 16'd4);
    wait_publish(400, p4);
    check("status_timeout", {30'd0, status}, 32'h1);
    withhold = -1;

    // Slow DRP: sweep outlasts the period, tick dropped
    lat = 40;
    vals[0] = 12'h111; vals[1] = 12'h222; vals[2] = 12'h333; vals[3] = 12'h444;
    threshold = 12'h333;
    daddr_q.delete();
    push_exp(32'h4433_2211, 4'b1100, 16'd5);
    wait_publish(500, p5);
    check("overrun_no_restart", daddr_q.size(), 4);
    check("status_overrun", {30'd0, status}, 32'h3);
    enable = 1'b0;

    // Disable during the ch1 read: no publish, outputs kept
    lat = 10;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (drp_den && (drp_daddr == 7'h11)) found = 1'b1;
    end
    check("ch1_read_seen", {31'd0, found}, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    dc = den_count;
    vc = valid_count;
    repeat (150) @(negedge clk);
    check("abort_no_den", den_count, dc);
    check("abort_no_valid", valid_count, vc);
    check("abort_net_out", net_out, 32'h4433_2211);
    check("abort_count", {16'd0, sample_count}, 32'd5);
    check("abort_spike", {28'd0, spike_bits}, 32'hC);
    vals[0] = 12'h0F0; vals[1] = 12'h0E0; vals[2] = 12'h0D0; vals[3] = 12'h0C0;
    threshold = 12'h000;
    push_exp(32'h0C0D_0E0F, 4'b1111, 16'd6);
    enable = 1'b1;
    wait_den(PERIOD + 5, n);
    check("reenable_latency", n, PERIOD);
    wait_publish(400, p6);

    // Reset while drp_den is high
    wait_den(PERIOD + 5, n);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_den(PERIOD + 5, n);
    check("post_reset_first_den", n, PERIOD);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
